// File: rtl/noc_rx_depacketizer_pkg.sv
// Shared NoC receive definitions: flit/ID widths, header field layout, error bits.
// Header flit: [3:0] dst_x, [7:4] dst_y, [11:8] src_x, [15:12] src_y, [23:16] LEN.
package noc_rx_depacketizer_pkg;

  localparam int NOC_DATA_W = 32;
  localparam int NOC_ID_X_W = 4;
  localparam int NOC_ID_Y_W = 4;
  localparam int NOC_LEN_W  = 8;

  localparam int HDR_DST_X_LSB = 0;
  localparam int HDR_DST_Y_LSB = 4;
  localparam int HDR_SRC_X_LSB = 8;
  localparam int HDR_SRC_Y_LSB = 12;
  localparam int HDR_LEN_LSB   = 16;

  localparam int ERR_DEST  = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_LEN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DISCARD
  } rx_state_e;

  typedef struct packed {
    logic [NOC_ID_X_W-1:0] src_x;
    logic [NOC_ID_Y_W-1:0] src_y;
    logic [NOC_ID_X_W-1:0] dst_x;
    logic [NOC_ID_Y_W-1:0] dst_y;
    logic [NOC_LEN_W-1:0]  len;
  } noc_hdr_t;

  function automatic noc_hdr_t decode_hdr(input logic [NOC_DATA_W-1:0] f);
    noc_hdr_t h;
    h.src_x = f[HDR_SRC_X_LSB +: NOC_ID_X_W];
    h.src_y = f[HDR_SRC_Y_LSB +: NOC_ID_Y_W];
    h.dst_x = f[HDR_DST_X_LSB +: NOC_ID_X_W];
    h.dst_y = f[HDR_DST_Y_LSB +: NOC_ID_Y_W];
    h.len   = f[HDR_LEN_LSB +: NOC_LEN_W];
    return h;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/noc_rx_hold_stage.sv
// Two-register payload stage: H holds the newest data flit until the next flit
// of the packet tells us whether it was the last one, then it moves to O.
module noc_rx_hold_stage
  import noc_rx_depacketizer_pkg::*;
(
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  load,
  input  logic [NOC_DATA_W-1:0] load_data,
  input  logic                  close,
  output logic                  can_accept,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NOC_DATA_W-1:0] out_data,
  output logic                  out_last
);

  logic                  h_vld_q, h_vld_d;
  logic [NOC_DATA_W-1:0] h_data_q, h_data_d;
  logic                  o_vld_q, o_vld_d;
  logic [NOC_DATA_W-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic                  move;

  // Caller only loads/closes when can_accept, so a move never overwrites a live O.
  assign can_accept = !o_vld_q || out_ready;

  always_comb begin
    move     = h_vld_q && (load || close);
    h_vld_d  = h_vld_q;
    h_data_d = h_data_q;
    o_vld_d  = o_vld_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    if (o_vld_q && out_ready) o_vld_d = 1'b0;
    if (move) begin
      o_vld_d  = 1'b1;
      o_data_d = h_data_q;
      o_last_d = close;
    end
    if (load) begin
      h_vld_d  = 1'b1;
      h_data_d = load_data;
    end else if (close) begin
      h_vld_d = 1'b0;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      h_vld_q  <= 1'b0;
      h_data_q <= '0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
      o_last_q <= 1'b0;
    end else begin
      h_vld_q  <= h_vld_d;
      h_data_q <= h_data_d;
      o_vld_q  <= o_vld_d;
      o_data_q <= o_data_d;
      o_last_q <= o_last_d;
    end
  end

  assign out_valid = o_vld_q;
  assign out_data  = o_data_q;
  assign out_last  = o_last_q;

endmodule

// File: rtl/noc_rx_depacketizer.sv
// NoC endpoint receiver: checks framing/destination, strips header and tail,
// streams payload downstream and reports per-packet status plus counters.
module noc_rx_depacketizer
  import noc_rx_depacketizer_pkg::*;
#(
  parameter logic [NOC_ID_X_W-1:0] X_ID       = '0,
  parameter logic [NOC_ID_Y_W-1:0] Y_ID       = '0,
  parameter bit                    CHECK_DEST = 1'b1
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [NOC_DATA_W-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NOC_DATA_W-1:0] out_data,
  output logic                  out_last,
  output logic                  pkt_done,
  output logic [NOC_ID_X_W-1:0] pkt_src_x,
  output logic [NOC_ID_Y_W-1:0] pkt_src_y,
  output logic [7:0]            pkt_len,
  output logic [2:0]            pkt_err,
  output logic [7:0]            pkt_cnt,
  output logic [7:0]            err_cnt
);

  rx_state_e             state_q, state_d;
  logic [NOC_ID_X_W-1:0] src_x_q, src_x_d;
  logic [NOC_ID_Y_W-1:0] src_y_q, src_y_d;
  logic [NOC_LEN_W-1:0]  len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  // Zero-payload header that arrived while closing another packet; reported next cycle.
  logic                  pend_q, pend_d;
  logic [NOC_ID_X_W-1:0] pend_x_q, pend_x_d;
  logic [NOC_ID_Y_W-1:0] pend_y_q, pend_y_d;
  logic                  pend_bad_q, pend_bad_d;

  logic                  pkt_done_q, pkt_done_d;
  logic [NOC_ID_X_W-1:0] pkt_src_x_q, pkt_src_x_d;
  logic [NOC_ID_Y_W-1:0] pkt_src_y_q, pkt_src_y_d;
  logic [7:0]            pkt_len_q, pkt_len_d;
  logic [2:0]            pkt_err_q, pkt_err_d;
  logic [7:0]            pkt_cnt_q, pkt_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  noc_hdr_t hdr;
  logic     acc, dest_bad, start, close, orphan;
  logic [2:0] close_err;
  logic     hs_load, hs_close, hs_can_accept;

  always_comb begin
    unique case (state_q)
      ST_IDLE:    receive_ready = !pend_q;
      ST_PAYLOAD: receive_ready = hs_can_accept;
      default:    receive_ready = 1'b1;
    endcase
  end

  assign acc      = receive_valid && receive_ready;
  assign hdr      = decode_hdr(receive_flit);
  assign dest_bad = CHECK_DEST && ({hdr.dst_x, hdr.dst_y} != {X_ID, Y_ID});

  always_comb begin
    state_d     = state_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_bad_d  = pend_bad_q;
    pkt_done_d  = 1'b0;
    pkt_src_x_d = pkt_src_x_q;
    pkt_src_y_d = pkt_src_y_q;
    pkt_len_d   = pkt_len_q;
    pkt_err_d   = pkt_err_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    start       = 1'b0;
    close       = 1'b0;
    close_err   = '0;
    orphan      = 1'b0;
    hs_load     = 1'b0;

    if (pend_q) begin
      pkt_done_d  = 1'b1;
      pkt_src_x_d = pend_x_q;
      pkt_src_y_d = pend_y_q;
      pkt_len_d   = '0;
      pkt_err_d   = {2'b00, pend_bad_q};
    end else if (acc) begin
      unique case (state_q)
        ST_PAYLOAD: begin
          if (receive_is_header) begin
            close = 1'b1;
            close_err[ERR_TRUNC] = 1'b1;
            start = 1'b1;
          end else if (receive_is_tail) begin
            close = 1'b1;
            close_err[ERR_LEN] = ({1'b0, cnt_q} != ({1'b0, len_q} + 9'd1));
            state_d = ST_IDLE;
          end else begin
            hs_load = 1'b1;
            cnt_d   = sat_inc8(cnt_q);
          end
        end
        ST_DISCARD: begin
          close_err[ERR_DEST] = 1'b1;
          if (receive_is_header) begin
            close = 1'b1;
            close_err[ERR_TRUNC] = 1'b1;
            start = 1'b1;
          end else if (receive_is_tail) begin
            close   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = sat_inc8(cnt_q);
          end
        end
        default: begin
          if (receive_is_header) start = 1'b1;
          else                   orphan = 1'b1;
        end
      endcase
    end

    if (close) begin
      pkt_done_d  = 1'b1;
      pkt_src_x_d = src_x_q;
      pkt_src_y_d = src_y_q;
      pkt_len_d   = cnt_q;
      pkt_err_d   = close_err;
    end

    if (start) begin
      if (receive_is_tail) begin
        state_d = ST_IDLE;
        if (close) begin
          pend_d     = 1'b1;
          pend_x_d   = hdr.src_x;
          pend_y_d   = hdr.src_y;
          pend_bad_d = dest_bad;
        end else begin
          pkt_done_d  = 1'b1;
          pkt_src_x_d = hdr.src_x;
          pkt_src_y_d = hdr.src_y;
          pkt_len_d   = '0;
          pkt_err_d   = {2'b00, dest_bad};
        end
      end else begin
        state_d = dest_bad ? ST_DISCARD : ST_PAYLOAD;
        src_x_d = hdr.src_x;
        src_y_d = hdr.src_y;
        len_d   = hdr.len;
        cnt_d   = '0;
      end
    end

    if (pkt_done_d) begin
      pkt_cnt_d = sat_inc8(pkt_cnt_q);
      if (pkt_err_d != 3'b000) err_cnt_d = sat_inc8(err_cnt_q);
    end
    if (orphan) err_cnt_d = sat_inc8(err_cnt_q);
  end

  assign hs_close = close;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q     <= ST_IDLE;
      src_x_q     <= '0;
      src_y_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_bad_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_src_x_q <= '0;
      pkt_src_y_q <= '0;
      pkt_len_q   <= '0;
      pkt_err_q   <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_bad_q  <= pend_bad_d;
      pkt_done_q  <= pkt_done_d;
      pkt_src_x_q <= pkt_src_x_d;
      pkt_src_y_q <= pkt_src_y_d;
      pkt_len_q   <= pkt_len_d;
      pkt_err_q   <= pkt_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  noc_rx_hold_stage u_hold (
    .noc_clk    (noc_clk),
    .noc_rst    (noc_rst),
    .load       (hs_load),
    .load_data  (receive_flit),
    .close      (hs_close),
    .can_accept (hs_can_accept),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  assign pkt_done  = pkt_done_q;
  assign pkt_src_x = pkt_src_x_q;
  assign pkt_src_y = pkt_src_y_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_err   = pkt_err_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_noc_rx_depacketizer.sv
// Scoreboard bench for noc_rx_depacketizer: packet-level reference model feeds
// expected beats/status into queues, an independent monitor pops and compares.
module tb_noc_rx_depacketizer;
  import noc_rx_depacketizer_pkg::*;

  logic        noc_clk = 1'b0;
  logic        noc_rst = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [31:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        pkt_done;
  logic [3:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [2:0]  pkt_err;
  logic [7:0]  pkt_cnt, err_cnt;

  always #5 noc_clk = ~noc_clk;

  noc_rx_depacketizer #(.X_ID(4'd0), .Y_ID(4'd0), .CHECK_DEST(1'b1)) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pkt_done(pkt_done), .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y),
    .pkt_len(pkt_len), .pkt_err(pkt_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [3:0] sx; logic [3:0] sy; logic [7:0] len; logic [2:0] err; } stat_t;

  beat_t exp_beats[$];
  stat_t exp_stats[$];
  int errors = 0;
  int checks = 0;
  int ready_mode = 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model (packet level) ----------------
  bit          m_in, m_disc, m_have;
  int          m_cnt, m_exp, e_pkt, e_err;
  logic [3:0]  m_sx, m_sy;
  logic [31:0] m_held;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic void push_stat(input logic [3:0] sx, input logic [3:0] sy,
                                    input int len, input logic [2:0] err);
    stat_t s;
    s.sx = sx; s.sy = sy; s.err = err;
    s.len = 8'((len > 255) ? 255 : len);
    exp_stats.push_back(s);
    e_pkt = sat(e_pkt);
    if (err != 3'b000) e_err = sat(e_err);
  endfunction

  function automatic void push_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    exp_beats.push_back(b);
  endfunction

  function automatic void m_close(input logic [2:0] err);
    if (m_have) push_beat(m_held, 1'b1);
    m_have = 0;
    push_stat(m_sx, m_sy, m_cnt, err);
    m_in = 0;
  endfunction

  function automatic void model_flit(input logic [31:0] d, input bit h, input bit t);
    bit bad;
    bad = (d[7:0] != 8'h00);
    if (h) begin
      if (m_in) m_close(m_disc ? 3'b011 : 3'b010);
      if (t) push_stat(d[11:8], d[15:12], 0, {2'b00, bad});
      else begin
        m_in = 1; m_disc = bad; m_cnt = 0; m_have = 0;
        m_exp = int'(d[23:16]) + 1; m_sx = d[11:8]; m_sy = d[15:12];
      end
    end else if (!m_in) begin
      e_err = sat(e_err);
    end else if (t) begin
      m_close(m_disc ? 3'b001 : {(m_cnt != m_exp), 2'b00});
    end else begin
      m_cnt++;
      if (!m_disc) begin
        if (m_have) push_beat(m_held, 1'b0);
        m_held = d; m_have = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_in = 0; m_have = 0; m_disc = 0; m_cnt = 0;
    e_pkt = 0; e_err = 0;
    exp_beats.delete();
    exp_stats.delete();
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [3:0] sx, input logic [3:0] sy,
                                         input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [7:0] len);
    return {8'h00, len, sy, sx, dy, dx};
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge noc_clk); #1;
      case (ready_mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b1;
        2: out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        stall_prev = 1'b0;
  logic        stall_l;
  logic [31:0] stall_d;
  beat_t       mb;
  stat_t       ms;

  initial begin
    forever begin
      @(negedge noc_clk);
      if (noc_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", {30'd0, out_valid, out_last, out_data}, {30'd0, 1'b1, stall_l, stall_d});
        if (out_valid && out_ready) begin
          if (exp_beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got data %0h last %0b, expected no beat", out_data, out_last);
          end else begin
            mb = exp_beats.pop_front();
            chk("beat", {31'd0, out_last, out_data}, {31'd0, mb.l, mb.d});
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_d = out_data;
        stall_l = out_last;
        if (pkt_done) begin
          if (exp_stats.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_unexpected: got src %0h,%0h len %0d err %0b, expected none",
                     pkt_src_x, pkt_src_y, pkt_len, pkt_err);
          end else begin
            ms = exp_stats.pop_front();
            chk("status", {45'd0, pkt_src_x, pkt_src_y, pkt_len, pkt_err},
                          {45'd0, ms.sx, ms.sy, ms.len, ms.err});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit h, input bit t);
    int n;
    n = 0;
    receive_valid = 1'b1; receive_flit = d;
    receive_is_header = h; receive_is_tail = t;
    while (1) begin
      @(negedge noc_clk);
      if (receive_ready) begin
        model_flit(d, h, t);
        break;
      end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL recv_ready_timeout: ready 0 for 200 cycles, expected 1");
        break;
      end
      @(posedge noc_clk); #1;
    end
    @(posedge noc_clk); #1;
    receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
  endtask

  task automatic pkt(input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] dx,
                     input logic [3:0] dy, input int len, input int nd, input bit tl);
    send(mk_hdr(sx, sy, dx, dy, 8'(len)), 1'b1, 1'b0);
    for (int i = 0; i < nd; i++) begin
      send($urandom, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    if (tl) send($urandom, 1'b0, 1'b1);
  endtask

  task automatic drain_check(input string name);
    ready_mode = 1;
    idle(12);
    chk({name, "_queues_empty"}, 64'(exp_beats.size() + exp_stats.size()), 64'd0);
    chk({name, "_pkt_cnt"}, {56'd0, pkt_cnt}, 64'(e_pkt));
    chk({name, "_err_cnt"}, {56'd0, err_cnt}, 64'(e_err));
  endtask

  int kk, ll, nd;
  bit bad, tl;
  logic [3:0] rdx;

  initial begin
    #1 noc_rst = 1'b1;
    #1;
    chk("reset_out", {29'd0, out_valid, out_last, out_data, pkt_done, receive_ready},
                     {29'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1});
    chk("reset_stat", {33'd0, pkt_src_x, pkt_src_y, pkt_len, pkt_err, pkt_cnt, err_cnt}, 64'd0);
    model_reset();
    @(posedge noc_clk); #1 noc_rst = 1'b0;

    // single-beat packet
    send(mk_hdr(4'd1, 4'd1, 4'd0, 4'd0, 8'd0), 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0, 1'b0, 1'b1);
    drain_check("single");

    // four beats with toggling back-pressure
    ready_mode = 2;
    pkt(4'd2, 4'd5, 4'd0, 4'd0, 3, 4, 1'b1);
    drain_check("toggle");

    // wrong destination is discarded
    pkt(4'd4, 4'd4, 4'd2, 4'd3, 1, 2, 1'b1);
    drain_check("bad_dest");

    // missing tail closed by the next header
    pkt(4'd3, 4'd1, 4'd0, 4'd0, 2, 1, 1'b0);
    pkt(4'd6, 4'd7, 4'd0, 4'd0, 0, 1, 1'b1);
    drain_check("trunc");

    // orphan data, then zero-payload header|tail
    send(32'hDEAD_BEEF, 1'b0, 1'b0);
    send(mk_hdr(4'd1, 4'd2, 4'd0, 4'd0, 8'd5), 1'b1, 1'b1);
    drain_check("orphan_zero");

    // randomized mix with back-pressure and malformed packets
    ready_mode = 0;
    for (int p = 0; p < 60; p++) begin
      kk  = $urandom_range(0, 9);
      bad = ($urandom_range(0, 7) == 0);
      rdx = bad ? 4'($urandom_range(1, 15)) : 4'd0;
      if (kk == 0) begin
        send($urandom, 1'b0, 1'b0);
      end else if (kk == 1) begin
        send(mk_hdr(4'($urandom), 4'($urandom), rdx, 4'd0, 8'd0), 1'b1, 1'b1);
      end else begin
        ll = $urandom_range(0, 5);
        nd = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : ll + 1;
        tl = ($urandom_range(0, 7) != 0);
        pkt(4'($urandom), 4'($urandom), rdx, 4'd0, ll, nd, tl);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    pkt(4'd9, 4'd9, 4'd0, 4'd0, 1, 2, 1'b1);
    drain_check("random");

    // reset in the middle of a payload with a full output register
    ready_mode = 3;
    idle(1);
    send(mk_hdr(4'd5, 4'd5, 4'd0, 4'd0, 8'd3), 1'b1, 1'b0);
    send(32'h1111_1111, 1'b0, 1'b0);
    send(32'h2222_2222, 1'b0, 1'b0);
    #2 noc_rst = 1'b1;
    #1;
    chk("midrst_out", {29'd0, out_valid, out_last, out_data, pkt_done, receive_ready},
                      {29'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1});
    chk("midrst_stat", {33'd0, pkt_src_x, pkt_src_y, pkt_len, pkt_err, pkt_cnt, err_cnt}, 64'd0);
    model_reset();
    @(posedge noc_clk); #1 noc_rst = 1'b0;
    ready_mode = 1;
    send(32'h3333_3333, 1'b0, 1'b1);
    drain_check("post_reset");

    // counter saturation
    for (int p = 0; p < 300; p++) pkt(4'($urandom), 4'($urandom), 4'd0, 4'd0, 0, 1, 1'b1);
    drain_check("saturate");
    chk("pkt_cnt_sat", {56'd0, pkt_cnt}, 64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
